// File: rtl/cpu_controller_mem_if.sv
// Decoder/datapath command bus for cpu_controller_mem, plus a state debug tap.
// Level-only bus: no valid/ready handshake; every field is a Moore output sampled by the datapath each clock.
interface cpu_controller_mem_if;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic        load_pc;
    logic        clear_pc;
    logic        load_ir;
    logic        load_addr;
    logic        sel_addr;
    logic        ram_w_en;
    logic [1:0]  reg_sel;
    logic [1:0]  wb_sel;
    logic        w_en;
    logic        en_A;
    logic        en_B;
    logic        en_C;
    logic        en_status;
    logic        sel_A;
    logic        sel_B;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;
    logic [4:0]  state_dbg;

    modport master (
        input  opcode, ALU_op,
        output load_pc, clear_pc, load_ir, load_addr, sel_addr, ram_w_en,
        output reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
        output sel_A, sel_B, halted, illegal, instr_count, state_dbg
    );

    modport slave (
        output opcode, ALU_op,
        input  load_pc, clear_pc, load_ir, load_addr, sel_addr, ram_w_en,
        input  reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
        input  sel_A, sel_B, halted, illegal, instr_count, state_dbg
    );
endinterface

// File: rtl/cpu_controller_mem.sv
// Multicycle CPU control FSM with memory-latency waits, LDR/STR sequencing, sticky HALT.
// Optional retired-instruction counter enabled by macro CPU_CTRL_INSTR_COUNT_EN.
module cpu_controller_mem #(
    parameter int MEM_LAT = 1,
    parameter int WR_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_controller_mem_if.master bus
);

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_PCINC, S_DECODE, S_MI, S_A, S_B, S_C, S_WB, S_S,
        S_CA, S_AD, S_MR, S_LW, S_BD, S_CD, S_MW, S_ILL, S_HALT
    } state_t;

    // Instruction class latched in DECODE; steers the shared A/B/C/AD steps.
    typedef enum logic [2:0] {K_ALU, K_MOV, K_CMP, K_LDR, K_STR} kind_t;

    localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0] WR_LAST  = 4'(WR_LAT - 1);

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = 4'd0;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == MEM_LAST) state_d = S_PCINC;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_PCINC:  state_d = S_DECODE;
            S_DECODE: begin
                casez ({bus.opcode, bus.ALU_op})
                    5'b110_10: state_d = S_MI;
                    5'b110_00, 5'b101_11: begin state_d = S_B; kind_d = K_MOV; end
                    5'b101_00, 5'b101_10: begin state_d = S_A; kind_d = K_ALU; end
                    5'b101_01: begin state_d = S_A; kind_d = K_CMP; end
                    5'b011_00: begin state_d = S_A; kind_d = K_LDR; end
                    5'b100_00: begin state_d = S_A; kind_d = K_STR; end
                    5'b111_??: state_d = S_HALT;
                    default:   state_d = S_ILL;
                endcase
            end
            S_A:  state_d = (kind_q == K_LDR || kind_q == K_STR) ? S_CA : S_B;
            S_B:  state_d = (kind_q == K_CMP) ? S_S : S_C;
            S_C:  state_d = S_WB;
            S_CA: state_d = S_AD;
            S_AD: state_d = (kind_q == K_LDR) ? S_MR : S_BD;
            S_MR: begin
                if (cnt_q == MEM_LAST) state_d = S_LW;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_BD: state_d = S_CD;
            S_CD: state_d = S_MW;
            S_MW: begin
                if (cnt_q == WR_LAST) state_d = S_FETCH;
                else                  cnt_d   = cnt_q + 4'd1;
            end
            S_MI, S_WB, S_S, S_LW, S_ILL: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
            kind_q  <= K_ALU;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.load_pc   = 1'b0;
        bus.clear_pc  = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_addr = 1'b0;
        bus.sel_addr  = 1'b0;
        bus.ram_w_en  = 1'b0;
        bus.reg_sel   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.w_en      = 1'b0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        bus.sel_B     = 1'b0;
        bus.halted    = 1'b0;
        bus.illegal   = 1'b0;
        case (state_q)
            S_RST:   begin bus.clear_pc = 1'b1; bus.load_pc = 1'b1; end
            S_FETCH: begin
                bus.sel_addr = 1'b1;
                bus.load_ir  = (cnt_q == MEM_LAST);
            end
            S_PCINC: bus.load_pc = 1'b1;
            S_MI:    begin bus.reg_sel = 2'b10; bus.wb_sel = 2'b10; bus.w_en = 1'b1; end
            S_A:     begin bus.en_A = 1'b1; bus.reg_sel = 2'b10; end
            S_B:     bus.en_B = 1'b1;
            // MOV/MVN pass B through the ALU with A forced to zero.
            S_C:     begin bus.en_C = 1'b1; bus.sel_A = (kind_q == K_MOV); end
            S_WB:    begin bus.w_en = 1'b1; bus.reg_sel = 2'b01; end
            S_S:     bus.en_status = 1'b1;
            S_CA:    begin bus.en_C = 1'b1; bus.sel_B = 1'b1; end
            S_AD:    bus.load_addr = 1'b1;
            S_LW:    begin bus.w_en = 1'b1; bus.reg_sel = 2'b01; bus.wb_sel = 2'b11; end
            S_BD:    begin bus.en_B = 1'b1; bus.reg_sel = 2'b01; end
            S_CD:    begin bus.en_C = 1'b1; bus.sel_A = 1'b1; end
            S_MW:    bus.ram_w_en = 1'b1;
            S_ILL:   bus.illegal = 1'b1;
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state_dbg = state_q;

`ifdef CPU_CTRL_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;
    logic        retire;

    // Only completed instructions count: ILL and RST also enter FETCH but are excluded.
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MI || state_q == S_WB || state_q == S_S ||
                     state_q == S_LW || state_q == S_MW);

    always_comb begin
        count_d = count_q;
        if (retire) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= 16'd0;
        else     count_q <= count_d;
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_controller_mem.sv
// Bench for cpu_controller_mem: two instances (MEM_LAT=1/WR_LAT=1 and MEM_LAT=3/WR_LAT=2)
// checked every cycle against a step-table model built from the instruction sequences.
module tb_cpu_controller_mem;

  localparam int ML0 = 1, WL0 = 1, ML1 = 3, WL1 = 2;

  typedef struct packed {
    logic       load_pc, clear_pc, load_ir, load_addr, sel_addr, ram_w_en;
    logic [1:0] reg_sel, wb_sel;
    logic       w_en, en_a, en_b, en_c, en_status, sel_a, sel_b, halted, illegal;
  } outs_t;

  typedef struct {
    bit          rst;
    logic [2:0]  op;
    logic [1:0]  alu;
    outs_t       o;
    logic [15:0] cnt;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  cpu_controller_mem_if if0 ();
  cpu_controller_mem_if if1 ();

  cpu_controller_mem #(.MEM_LAT(ML0), .WR_LAT(WL0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  cpu_controller_mem #(.MEM_LAT(ML1), .WR_LAT(WL1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  outs_t act0, act1;
  assign act0 = {if0.load_pc, if0.clear_pc, if0.load_ir, if0.load_addr, if0.sel_addr, if0.ram_w_en,
                 if0.reg_sel, if0.wb_sel, if0.w_en, if0.en_A, if0.en_B, if0.en_C, if0.en_status,
                 if0.sel_A, if0.sel_B, if0.halted, if0.illegal};
  assign act1 = {if1.load_pc, if1.clear_pc, if1.load_ir, if1.load_addr, if1.sel_addr, if1.ram_w_en,
                 if1.reg_sel, if1.wb_sel, if1.w_en, if1.en_A, if1.en_B, if1.en_C, if1.en_status,
                 if1.sel_A, if1.sel_B, if1.halted, if1.illegal};

  // ---------------- model ----------------
  ent_t        exp_q0[$], exp_q1[$], tmp_q[$];
  bit          tmp_done;
  logic [15:0] cnt_m[2];
  int          errors = 0, checks = 0;
  bit          go = 0, done0 = 0, done1 = 0;

  function automatic outs_t step(string s);
    outs_t o = '0;
    if (s == "RST")             begin o.clear_pc = 1; o.load_pc = 1; end
    else if (s == "FETCH")      o.sel_addr = 1;
    else if (s == "FETCH_LAST") begin o.sel_addr = 1; o.load_ir = 1; end
    else if (s == "PCINC")      o.load_pc = 1;
    else if (s == "MI")         begin o.reg_sel = 2'b10; o.wb_sel = 2'b10; o.w_en = 1; end
    else if (s == "A")          begin o.en_a = 1; o.reg_sel = 2'b10; end
    else if (s == "B")          o.en_b = 1;
    else if (s == "C")          o.en_c = 1;
    else if (s == "C0")         begin o.en_c = 1; o.sel_a = 1; end
    else if (s == "WB")         begin o.w_en = 1; o.reg_sel = 2'b01; end
    else if (s == "S")          o.en_status = 1;
    else if (s == "CA")         begin o.en_c = 1; o.sel_b = 1; end
    else if (s == "AD")         o.load_addr = 1;
    else if (s == "LW")         begin o.w_en = 1; o.reg_sel = 2'b01; o.wb_sel = 2'b11; end
    else if (s == "BD")         begin o.en_b = 1; o.reg_sel = 2'b01; end
    else if (s == "MW")         o.ram_w_en = 1;
    else if (s == "ILL")        o.illegal = 1;
    else if (s == "HALT")       o.halted = 1;
    return o;  // DECODE and MR drive nothing
  endfunction

  function automatic logic [15:0] exp_cnt(input int sel);
`ifdef CPU_CTRL_INSTR_COUNT_EN
    return cnt_m[sel];
`else
    return 16'd0;
`endif
  endfunction

  task automatic push(input int sel, input ent_t e);
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  // Inputs outside DECODE are random: the controller must ignore them.
  task automatic put(input string s);
    ent_t e;
    e.rst = 0;
    e.op  = 3'($urandom_range(0, 7));
    e.alu = 2'($urandom_range(0, 3));
    e.o   = step(s);
    e.cnt = '0;
    tmp_q.push_back(e);
  endtask

  task automatic build(input int sel, input logic [2:0] op, input logic [1:0] alu, input int halt_n);
    int    ml = (sel == 0) ? ML0 : ML1;
    int    wl = (sel == 0) ? WL0 : WL1;
    string seq[$];
    tmp_q.delete();
    tmp_done = 1;
    for (int i = 0; i < ml; i++) put((i == ml - 1) ? "FETCH_LAST" : "FETCH");
    put("PCINC");
    put("DECODE");
    tmp_q[tmp_q.size()-1].op  = op;
    tmp_q[tmp_q.size()-1].alu = alu;
    if (op == 3'b111) begin
      for (int i = 0; i < halt_n; i++) seq.push_back("HALT");
      tmp_done = 0;
    end else if ({op, alu} == 5'b110_10) seq.push_back("MI");
    else if ({op, alu} == 5'b110_00 || {op, alu} == 5'b101_11) begin
      seq.push_back("B"); seq.push_back("C0"); seq.push_back("WB");
    end else if ({op, alu} == 5'b101_00 || {op, alu} == 5'b101_10) begin
      seq.push_back("A"); seq.push_back("B"); seq.push_back("C"); seq.push_back("WB");
    end else if ({op, alu} == 5'b101_01) begin
      seq.push_back("A"); seq.push_back("B"); seq.push_back("S");
    end else if ({op, alu} == 5'b011_00) begin
      seq.push_back("A"); seq.push_back("CA"); seq.push_back("AD");
      for (int i = 0; i < ml; i++) seq.push_back("MR");
      seq.push_back("LW");
    end else if ({op, alu} == 5'b100_00) begin
      seq.push_back("A"); seq.push_back("CA"); seq.push_back("AD");
      seq.push_back("BD"); seq.push_back("C0");
      for (int i = 0; i < wl; i++) seq.push_back("MW");
    end else begin
      seq.push_back("ILL");
      tmp_done = 0;
    end
    foreach (seq[i]) put(seq[i]);
  endtask

  // Push the first n model cycles (all when n < 0); a full completed instruction retires.
  task automatic emit(input int sel, input int n);
    int lim = (n < 0) ? tmp_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      ent_t e = tmp_q[i];
      e.cnt = exp_cnt(sel);
      push(sel, e);
    end
    if (n < 0 && tmp_done) cnt_m[sel] = cnt_m[sel] + 16'd1;
  endtask

  task automatic run(input int sel, input logic [2:0] op, input logic [1:0] alu);
    build(sel, op, alu, 20);
    emit(sel, -1);
  endtask

  // rst is raised during the last queued cycle; RST state follows for `cycles` cycles.
  task automatic reset_seq(input int sel, input int cycles);
    ent_t e;
    if (sel == 0 && exp_q0.size() > 0) exp_q0[exp_q0.size()-1].rst = 1;
    if (sel == 1 && exp_q1.size() > 0) exp_q1[exp_q1.size()-1].rst = 1;
    cnt_m[sel] = 16'd0;
    for (int i = 0; i < cycles; i++) begin
      e.rst = (i < cycles - 1);
      e.op  = 3'($urandom_range(0, 7));
      e.alu = 2'($urandom_range(0, 3));
      e.o   = step("RST");
      e.cnt = exp_cnt(sel);
      push(sel, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic compare(input int sel, input int cyc, input outs_t act, input logic [15:0] cnt, input ent_t e);
    checks++;
    if (act !== e.o) begin
      errors++;
      $display("FAIL dut%0d cyc%0d outputs: got %05h expected %05h", sel, cyc, act, e.o);
    end
    checks++;
    if (cnt !== e.cnt) begin
      errors++;
      $display("FAIL dut%0d cyc%0d instr_count: got %0d expected %0d", sel, cyc, cnt, e.cnt);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    int   cyc0 = 0, cyc1 = 0;
    ent_t e;
    wait (go);
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        compare(0, cyc0, act0, if0.instr_count, e);
        cyc0++;
        if0.opcode = e.op; if0.ALU_op = e.alu; rst0 = e.rst;
        if (exp_q0.size() == 0) done0 = 1;
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        compare(1, cyc1, act1, if1.instr_count, e);
        cyc1++;
        if1.opcode = e.op; if1.ALU_op = e.alu; rst1 = e.rst;
        if (exp_q1.size() == 0) done1 = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst0 = 1; rst1 = 1;
    if0.opcode = '0; if0.ALU_op = '0;
    if1.opcode = '0; if1.ALU_op = '0;
    cnt_m[0] = '0; cnt_m[1] = '0;

    check_int("pin_mi_word", int'(step("MI")), 32'h01500);
    check_int("pin_lw_word", int'(step("LW")), 32'h00F00);

    // Instance 0: MEM_LAT=1, WR_LAT=1
    reset_seq(0, 2);
    build(0, 3'b110, 2'b10, 0); check_int("pin_movi_len", tmp_q.size(), 4);  emit(0, -1);
    build(0, 3'b101, 2'b00, 0); check_int("pin_add_len", tmp_q.size(), 7);   emit(0, -1);
    run(0, 3'b110, 2'b00);
    run(0, 3'b101, 2'b10);
    build(0, 3'b101, 2'b01, 0); check_int("pin_cmp_len", tmp_q.size(), 6);   emit(0, -1);
    run(0, 3'b101, 2'b11);
    run(0, 3'b011, 2'b00);
    run(0, 3'b100, 2'b00);
    run(0, 3'b010, 2'b00);
    run(0, 3'b000, 2'b00);
    run(0, 3'b110, 2'b01);
    run(0, 3'b011, 2'b01);
    run(0, 3'b110, 2'b10);
    run(0, 3'b111, 2'b00);
    reset_seq(0, 1);
    run(0, 3'b110, 2'b10);

    // Instance 1: MEM_LAT=3, WR_LAT=2
    reset_seq(1, 2);
    build(1, 3'b011, 2'b00, 0); check_int("pin_ldr3_len", tmp_q.size(), 12); emit(1, -1);
    build(1, 3'b100, 2'b00, 0); check_int("pin_str2_len", tmp_q.size(), 12); emit(1, -1);
    run(1, 3'b110, 2'b10);
    build(1, 3'b011, 2'b00, 0);
    emit(1, 10);  // stop in the second MR cycle
    reset_seq(1, 1);
    run(1, 3'b101, 2'b00);
    build(1, 3'b111, 2'b11, 5); emit(1, -1);
    reset_seq(1, 1);
    run(1, 3'b110, 2'b10);

    go = 1;
    for (int i = 0; i < 5000 && !(done0 && done1); i++) @(posedge clk);
    if (!(done0 && done1)) begin
      errors++;
      $display("FAIL timeout: queues not drained (done0=%0d done1=%0d)", done0, done1);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
